// File: rtl/crc_stream_pkg.sv
// Shared types and constants for the CRC framer/checker stream block.
package crc_stream_pkg;

    typedef enum logic {
        ST_PAYLOAD = 1'b0,
        ST_CRC_OUT = 1'b1
    } state_t;

    localparam int MODE_TX = 0;
    localparam int MODE_RX = 1;

    function automatic int crc_bytes(input int crc_w);
        return crc_w / 8;
    endfunction

endpackage

// File: rtl/crc_byte_engine.sv
// One-byte CRC update, MSB-first, non-reflected, unrolled over the 8 data bits.
module crc_byte_engine #(
    parameter int               CRC_W      = 8,
    parameter logic [CRC_W-1:0] POLYNOMIAL = CRC_W'(8'h07)
) (
    input  logic [CRC_W-1:0] crc_i,
    input  logic [7:0]       data_i,
    output logic [CRC_W-1:0] crc_o
);

    always_comb begin
        crc_o = crc_i;
        for (int i = 7; i >= 0; i--) begin
            if (crc_o[CRC_W-1] ^ data_i[i]) begin
                crc_o = (crc_o << 1) ^ POLYNOMIAL;
            end else begin
                crc_o = crc_o << 1;
            end
        end
    end

endmodule

// File: rtl/crc_frame_stream.sv
// CRC framer (TX: append CRC) / checker (RX: verify trailing CRC) on a zero-latency valid/ready byte stream.
//  state      | meaning
//  ST_PAYLOAD | payload bytes pass through, CRC register accumulates
//  ST_CRC_OUT | CRC register frozen; TX emits CRC bytes, RX compares incoming CRC bytes
module crc_frame_stream
    import crc_stream_pkg::*;
#(
    parameter int               CRC_W         = 8,
    parameter logic [CRC_W-1:0] POLYNOMIAL    = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] INITIAL       = CRC_W'(8'hFF),
    parameter int               PAYLOAD_BYTES = 8,
    parameter int               MODE          = MODE_TX
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sync_i,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [7:0]  byte_counter,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] err_count
);

    localparam int CRC_BYTES = crc_bytes(CRC_W);
    localparam int TOTAL     = PAYLOAD_BYTES + CRC_BYTES;

    state_t             state_q, state_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic               mism_q, mism_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    logic [CRC_W-1:0]   crc_upd;
    logic [CRC_W-1:0]   crc_restart;
    logic [8:0]         crc_idx;
    logic [7:0]         crc_byte;
    logic               last_beat;
    logic               xfer;
    logic               s_acc;

    crc_byte_engine #(.CRC_W(CRC_W), .POLYNOMIAL(POLYNOMIAL)) u_eng_run (
        .crc_i  (crc_q),
        .data_i (s_data),
        .crc_o  (crc_upd)
    );

    // Separate engine seeded with INITIAL so a beat coinciding with sync_i starts a fresh frame.
    crc_byte_engine #(.CRC_W(CRC_W), .POLYNOMIAL(POLYNOMIAL)) u_eng_sync (
        .crc_i  (INITIAL),
        .data_i (s_data),
        .crc_o  (crc_restart)
    );

    assign crc_idx   = cnt_q - 9'(PAYLOAD_BYTES);
    assign last_beat = (state_q == ST_CRC_OUT) && (cnt_q == 9'(TOTAL - 1));

    always_comb begin
        crc_byte = 8'h00;
        for (int b = 0; b < CRC_BYTES; b++) begin
            if (crc_idx == 9'(b)) crc_byte = crc_q[CRC_W-1-8*b -: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_PAYLOAD;
            cnt_q     <= '0;
            crc_q     <= INITIAL;
            mism_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            mism_q    <= mism_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        mism_d    = mism_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        m_data    = s_data;
        m_valid   = s_valid;
        s_ready   = m_ready;
        m_last    = 1'b0;

        if (state_q == ST_CRC_OUT) begin
            m_last = last_beat;
            if (MODE == MODE_TX) begin
                s_ready = 1'b0;
                m_valid = 1'b1;
                m_data  = crc_byte;
            end
        end

        xfer  = m_valid & m_ready;
        s_acc = s_valid & s_ready;

        if (xfer) begin
            if (state_q == ST_PAYLOAD) begin
                crc_d = crc_upd;
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == 9'(PAYLOAD_BYTES - 1)) state_d = ST_CRC_OUT;
            end else begin
                if (MODE == MODE_RX && s_data != crc_byte) mism_d = 1'b1;
                if (last_beat) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = '0;
                    crc_d   = INITIAL;
                    mism_d  = 1'b0;
                    if (MODE == MODE_RX) begin
                        if (mism_q || s_data != crc_byte) err_d = 1'b1;
                        else                              ok_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
        end

        if (sync_i) begin
            ok_d   = 1'b0;
            err_d  = 1'b0;
            mism_d = 1'b0;
            if (s_acc) begin
                cnt_d   = 9'd1;
                crc_d   = crc_restart;
                state_d = (PAYLOAD_BYTES == 1) ? ST_CRC_OUT : ST_PAYLOAD;
            end else begin
                cnt_d   = '0;
                crc_d   = INITIAL;
                state_d = ST_PAYLOAD;
            end
        end

        if (err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    assign byte_counter = cnt_q[7:0];
    assign frame_ok     = (MODE == MODE_RX) ? ok_q  : 1'b0;
    assign frame_err    = (MODE == MODE_RX) ? err_q : 1'b0;
    assign err_count    = (MODE == MODE_RX) ? err_cnt_q : 16'h0000;

endmodule
